regfile_onehot_wr: RTL



---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_onehot_wr_enc.sv | 27 ++
 rtl/regfile_onehot_wr.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 8-entry one-hot-written register file.
//   NREG        : number of registers (tied to the 3-bit address space)
//   REG_ADDR_W  : register address width
//   data_t      : default-width register word
//   is_onehot() : true when exactly one bit of an enable vector is set
//   onehot_to_idx() : binary index of a one-hot vector (OR of set-bit indices)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int NREG       = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  typedef logic [DEF_DATA_W-1:0] data_t;

  // A vector is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  function automatic logic is_onehot(input logic [NREG-1:0] vec);
    return (vec != '0) && ((vec & (vec - NREG'(1))) == '0);
  endfunction

  // Only meaningful for one-hot input; multi-hot vectors give the OR of indices.
  function automatic logic [REG_ADDR_W-1:0] onehot_to_idx(input logic [NREG-1:0] vec);
    logic [REG_ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (vec[i]) idx = idx | REG_ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_onehot_wr_enc.sv
// -----------------------------------------------------------------------------
// onehot_enc8
// Classifies an 8-bit write-enable vector and encodes it to a binary index.
// Ports:
//   i_vec      in  [7:0]  enable vector from the write-address demux
//   o_valid    out        exactly one bit set
//   o_multihot out        two or more bits set
//   o_idx      out [2:0]  index of the set bit (valid only when o_valid)
// -----------------------------------------------------------------------------
module onehot_enc8
  import regfile_pkg::*;
(
  input  logic [7:0] i_vec,
  output logic       o_valid,
  output logic       o_multihot,
  output logic [2:0] o_idx
);

  logic w_onehot;

  assign w_onehot   = is_onehot(i_vec);
  assign o_valid    = w_onehot;
  // Non-zero but not one-hot means at least two bits are set.
  assign o_multihot = (i_vec != 8'h00) && !w_onehot;
  assign o_idx      = onehot_to_idx(i_vec);

endmodule

// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
// 8-entry register file written through a one-hot enable vector, with two
// registered read ports, same-cycle write-to-read forwarding, a sticky
// multi-hot error flag and a wrapping count of accepted writes.
//
// Build option:
//   REGFILE_R0_ZERO_EN  when defined, register 0 is hard-wired to zero (reads
//                       and forwarding return 0); writes to it are dropped
//                       but still counted in wr_count.
//
// Ports:
//   clk           in              rising-edge clock
//   rst_n         in              asynchronous active-low reset
//   we_onehot     in  [7:0]       one-hot write enable (0 = no write)
//   wdata         in  [DATA_W-1:0] write-back data
//   rd_en         in              read strobe, captures both ports
//   rd_addr_a/b   in  [2:0]       read addresses
//   rdata_a/b     out [DATA_W-1:0] registered read data
//   rd_valid      out             high the cycle after an accepted rd_en
//   err_multihot  out             sticky multi-hot enable flag
//   err_clr       in              clears err_multihot (a new error wins)
//   wr_count      out [15:0]      accepted writes, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module regfile_onehot_wr #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        we_onehot,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [2:0]        rd_addr_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rd_valid,
  output logic              err_multihot,
  input  logic              err_clr,
  output logic [15:0]       wr_count
);

  import regfile_pkg::*;

  if (NREG != 8) begin : g_nreg_check
    $error("regfile_onehot_wr: NREG must be 8 to match the 3-bit address space");
  end

  logic                  w_wr_valid;
  logic                  w_wr_multihot;
  logic [REG_ADDR_W-1:0] w_wr_idx;
  logic                  w_wr_store;
  logic [DATA_W-1:0]     w_rd_a_p0;
  logic [DATA_W-1:0]     w_rd_b_p0;

  logic [DATA_W-1:0]     r_regs [NREG];
  logic [DATA_W-1:0]     r_rdata_a_p1;
  logic [DATA_W-1:0]     r_rdata_b_p1;
  logic                  r_vld_p1;
  logic                  r_err;
  logic [15:0]           r_wr_count;

  // One encoder serves both the register write and the forwarding compare,
  // so a rejected multi-hot vector can never forward.
  onehot_enc8 u_wr_enc (
    .i_vec      (we_onehot),
    .o_valid    (w_wr_valid),
    .o_multihot (w_wr_multihot),
    .o_idx      (w_wr_idx)
  );

`ifdef REGFILE_R0_ZERO_EN
  assign w_wr_store = w_wr_valid && (w_wr_idx != '0);
`else
  assign w_wr_store = w_wr_valid;
`endif

  // Read mux with bypass of the write happening on the same edge.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [2:0]        addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_ok,
    input logic [2:0]        wr_idx,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] val;
    if (wr_ok && (wr_idx == addr)) val = wr_data;
    else                           val = stored;
`ifdef REGFILE_R0_ZERO_EN
    if (addr == 3'd0) val = '0;
`endif
    return val;
  endfunction

  // ---- stage p0: register array write, combinational read/forward ----
  assign w_rd_a_p0 = fwd_sel(rd_addr_a, r_regs[rd_addr_a], w_wr_valid, w_wr_idx, wdata);
  assign w_rd_b_p0 = fwd_sel(rd_addr_b, r_regs[rd_addr_b], w_wr_valid, w_wr_idx, wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_store) begin
      r_regs[w_wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      // Set has priority over clear.
      if (w_wr_multihot)  r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
      if (w_wr_valid)     r_wr_count <= r_wr_count + 16'd1;
    end
  end

  // ---- stage p1: registered read ports ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_rdata_a_p1 <= '0;
      r_rdata_b_p1 <= '0;
    end else begin
      r_vld_p1 <= rd_en;
      if (rd_en) begin
        r_rdata_a_p1 <= w_rd_a_p0;
        r_rdata_b_p1 <= w_rd_b_p0;
      end
    end
  end

  assign rdata_a      = r_rdata_a_p1;
  assign rdata_b      = r_rdata_b_p1;
  assign rd_valid     = r_vld_p1;
  assign err_multihot = r_err;
  assign wr_count     = r_wr_count;

endmodule
